// File: rtl/serial_link_pkg.sv
// serial_link_pkg
// Shared constants and types for the serial link transmit path.
//   LANE_W / WORD_W / BEATS_PER_WORD : lane nibble width, payload word width,
//                                      data beats per word.
//   HDR_MARK                         : marker bits in the upper half of the header nibble.
//   tx_state_e                       : transmit FSM state encoding.
//   hdr_t                            : header nibble layout {mark, id}.
// Macro SERIAL_LINK_PARITY_EN adds the PAR state (even-parity trailer beat).
package serial_link_pkg;

    localparam int LANE_W         = 4;
    localparam int WORD_W         = 32;
    localparam int BEATS_PER_WORD = 8;
    localparam logic [1:0] HDR_MARK = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
`ifdef SERIAL_LINK_PARITY_EN
        ,
        ST_PAR  = 2'd3
`endif
    } tx_state_e;

    typedef struct packed {
        logic [1:0] mark;
        logic [1:0] id;
    } hdr_t;

endpackage

// File: rtl/serial_link_rr_arb.sv
// serial_link_rr_arb
// Combinational round-robin grant. The search starts at last_grant+1 (mod
// NUM_REQ) and takes the first requester that is asserting.
//   req        : request vector, one bit per requester
//   last_grant : ID of the most recent winner (pointer lives in the parent)
//   gnt        : one-hot grant, all-zero when nobody requests
//   gnt_id     : binary ID of the winner (0 when nobody requests)
//   gnt_any    : at least one requester is asserting
module serial_link_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_id,
    output logic               gnt_any
);

    always_comb begin
        logic found;
        gnt    = '0;
        gnt_id = 2'd0;
        found  = 1'b0;
        // Offset i = 1 is the requester right after the last winner; the
        // last winner itself is checked last (offset NUM_REQ).
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (j == ((int'(last_grant) + i) % NUM_REQ)) && req[j]) begin
                    found  = 1'b1;
                    gnt[j] = 1'b1;
                    gnt_id = 2'(j);
                end
            end
        end
    end

    assign gnt_any = |req;

endmodule

// File: rtl/serial_link_tx_arbiter.sv
// serial_link_tx_arbiter
// Transmit scheduler for the 4-bit serial lane. Up to four requesters share
// the lane round-robin; each accepted 32-bit word goes out as one header
// nibble {2'b10, id} followed by eight data nibbles, LSB nibble first.
// With SERIAL_LINK_PARITY_EN defined a trailing even-parity beat is appended.
//
// Handshake: a word transfers in the cycle where req_valid_i[g] and
// req_ready_o[g] are both high. req_ready_o is at most one-hot and only rises
// at an accept point (IDLE, or the final beat of a frame) while the
// synchronized remote-full flag is low. Requesters may drop valid at any
// time; only accepted words are sent.
//
// Ports:
//   clk_i         : clock (clk_gen domain)
//   rst_i         : synchronous active-high reset; aborts any frame
//   req_valid_i   : per-requester word valid
//   req_data_i    : per-requester 32-bit word
//   req_ready_o   : one-hot accept (combinational)
//   remote_full_i : remote FIFO full, asynchronous; 2-flop synchronized
//   lane_data_o   : registered lane nibble
//   lane_valid_o  : registered nibble strobe
//   busy_o        : frame on the lane (equals lane_valid_o)
//   grant_id_o    : ID of the frame on the lane, held until the next grant
//   dbg_state_o   : current FSM state (tx_state_e encoding)
module serial_link_tx_arbiter
    import serial_link_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0][WORD_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic                           remote_full_i,
    output logic [LANE_W-1:0]              lane_data_o,
    output logic                           lane_valid_o,
    output logic                           busy_o,
    output logic [1:0]                     grant_id_o,
    output logic [1:0]                     dbg_state_o
);

    localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_WORD - 1);

    tx_state_e          state;
    logic [2:0]         beat_cnt;
    logic [2:0]         beat_nxt;
    logic [WORD_W-1:0]  word_q;
    logic [1:0]         grant_id_q;
    logic [1:0]         last_grant;
    logic [LANE_W-1:0]  lane_data_q;
    logic               lane_valid_q;
    logic               full_meta;
    logic               full_sync;

    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_id;
    logic               gnt_any;
    logic [WORD_W-1:0]  gnt_data;
    logic               final_beat;
    logic               accept;
    hdr_t               hdr_next;

    serial_link_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .req        (req_valid_i),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .gnt_any    (gnt_any)
    );

    // Word of the winning requester; the grant is one-hot so an OR-mux suffices.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_data = gnt_data | req_data_i[i];
            end
        end
    end

`ifdef SERIAL_LINK_PARITY_EN
    assign final_beat = (state == ST_PAR);
`else
    assign final_beat = (state == ST_DATA) && (beat_cnt == LAST_BEAT);
`endif

    // Full is only consulted here; a frame already on the lane always finishes
    // because the remote FIFO keeps one frame of headroom.
    assign accept = !rst_i && ((state == ST_IDLE) || final_beat) && !full_sync && gnt_any;

    assign req_ready_o = accept ? gnt : '0;

    assign hdr_next.mark = HDR_MARK;
    assign hdr_next.id   = gnt_id;
    assign beat_nxt      = beat_cnt + 3'd1;

    // state always names what the lane registers are currently showing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_meta    <= 1'b0;
            full_sync    <= 1'b0;
            state        <= ST_IDLE;
            beat_cnt     <= 3'd0;
            word_q       <= '0;
            grant_id_q   <= 2'd0;
            last_grant   <= 2'(NUM_REQ - 1);
            lane_data_q  <= '0;
            lane_valid_q <= 1'b0;
        end else begin
            full_meta <= remote_full_i;
            full_sync <= full_meta;
            if (accept) begin
                state        <= ST_HDR;
                word_q       <= gnt_data;
                grant_id_q   <= gnt_id;
                last_grant   <= gnt_id;
                beat_cnt     <= 3'd0;
                lane_data_q  <= hdr_next;
                lane_valid_q <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        lane_data_q  <= '0;
                        lane_valid_q <= 1'b0;
                    end
                    ST_HDR: begin
                        state        <= ST_DATA;
                        beat_cnt     <= 3'd0;
                        lane_data_q  <= word_q[LANE_W-1:0];
                        lane_valid_q <= 1'b1;
                    end
                    ST_DATA: begin
                        if (beat_cnt == LAST_BEAT) begin
`ifdef SERIAL_LINK_PARITY_EN
                            state        <= ST_PAR;
                            lane_data_q  <= {3'b000, ^word_q};
                            lane_valid_q <= 1'b1;
`else
                            state        <= ST_IDLE;
                            lane_data_q  <= '0;
                            lane_valid_q <= 1'b0;
`endif
                        end else begin
                            beat_cnt     <= beat_nxt;
                            lane_data_q  <= word_q[{beat_nxt, 2'b00} +: LANE_W];
                            lane_valid_q <= 1'b1;
                        end
                    end
`ifdef SERIAL_LINK_PARITY_EN
                    ST_PAR: begin
                        state        <= ST_IDLE;
                        lane_data_q  <= '0;
                        lane_valid_q <= 1'b0;
                    end
`endif
                    default: begin
                        state        <= ST_IDLE;
                        lane_data_q  <= '0;
                        lane_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lane_data_o  = lane_data_q;
    assign lane_valid_o = lane_valid_q;
    assign busy_o       = lane_valid_q;
    assign grant_id_o   = grant_id_q;
    assign dbg_state_o  = state;

endmodule

// File: tb/tb_serial_link_tx_arbiter.sv
// tb_serial_link_tx_arbiter
// Directed bench for serial_link_tx_arbiter with NUM_REQ=2. Expected lane
// nibbles are queued per frame from the word and ID and popped beat by beat.
module tb_serial_link_tx_arbiter;

`ifdef SERIAL_LINK_PARITY_EN
    localparam int FRAME = 10;
`else
    localparam int FRAME = 9;
`endif

    localparam logic [31:0] W0 = 32'h89AB_CDEF;
    localparam logic [31:0] W1 = 32'h1234_5678;

    logic             clk;
    logic             rst_i;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_data;
    logic [1:0]       req_ready;
    logic             remote_full;
    logic [3:0]       lane_data;
    logic             lane_valid;
    logic             busy;
    logic [1:0]       grant_id;
    logic [1:0]       dbg_state;

    logic [3:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_link_tx_arbiter #(
        .NUM_REQ (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .remote_full_i (remote_full),
        .lane_data_o   (lane_data),
        .lane_valid_o  (lane_valid),
        .busy_o        (busy),
        .grant_id_o    (grant_id),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver helpers ----------------
    // Move to a point well after the next rising edge; outputs are stable here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_frame(input logic [1:0] id, input logic [31:0] w);
        exp_q.push_back({2'b10, id});
        for (int k = 0; k < 8; k++) exp_q.push_back(w[4*k +: 4]);
`ifdef SERIAL_LINK_PARITY_EN
        exp_q.push_back({3'b000, ^w});
`endif
    endtask

    task automatic check_beat(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expected queue empty at %0t", tag, $time);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_data"}, 32'(lane_data), 32'(e));
            check_eq({tag, "_valid"}, 32'(lane_valid), 32'd1);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 32'(lane_valid), 32'd0);
        check_eq({tag, "_data"}, 32'(lane_data), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] id;
        logic [1:0] nxt_hot;

        rst_i       = 1'b1;
        req_valid   = 2'b00;
        req_data[0] = W0;
        req_data[1] = W1;
        remote_full = 1'b0;
        repeat (3) tick();

        // Reset state, ready forced low under reset even with requests.
        req_valid = 2'b11;
        #1;
        check_idle("reset");
        check_eq("reset_grant_id", 32'(grant_id), 32'd0);
        check_eq("reset_state", 32'(dbg_state), 32'd0);
        check_eq("reset_ready", 32'(req_ready), 32'd0);

        // Single word from requester 0.
        req_valid = 2'b01;
        rst_i     = 1'b0;
        #1;
        check_eq("single_ready", 32'(req_ready), 32'h1);
        push_frame(2'd0, W0);
        tick();
        req_valid = 2'b00;
        #1;
        check_eq("single_ready_after", 32'(req_ready), 32'h0);
        check_eq("single_grant_id", 32'(grant_id), 32'd0);
        check_eq("single_busy", 32'(busy), 32'd1);
        for (int b = 0; b < FRAME; b++) begin
            check_beat("single");
            tick();
        end
        check_idle("single_end");

        // Reset mid-frame: requester 1 (pointer now at 0) goes first.
        req_valid = 2'b10;
        #1;
        check_eq("rst_mid_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        check_eq("rst_mid_hdr", 32'(lane_data), 32'h9);
        check_eq("rst_mid_grant_id", 32'(grant_id), 32'd1);
        repeat (5) tick();
        check_eq("rst_mid_beat4", 32'(lane_data), 32'h4);
        rst_i     = 1'b1;
        req_valid = 2'b11;
        #1;
        check_eq("rst_mid_ready_in_rst", 32'(req_ready), 32'h0);
        tick();
        check_idle("rst_mid_after");
        check_eq("rst_mid_grant_clr", 32'(grant_id), 32'd0);

        // Fairness: both valid, grants 0,1,0,1 with frames back to back.
        rst_i = 1'b0;
        #1;
        check_eq("fair_ready0", 32'(req_ready), 32'h1);
        for (int f = 0; f < 4; f++) begin
            id = (f % 2 == 0) ? 2'd0 : 2'd1;
            nxt_hot = (id == 2'd0) ? 2'b10 : 2'b01;
            push_frame(id, (id == 2'd0) ? W0 : W1);
            tick();
            check_eq("fair_grant_id", 32'(grant_id), 32'(id));
            check_eq("fair_hdr_ready", 32'(req_ready), 32'h0);
            for (int b = 0; b < FRAME; b++) begin
                check_beat("fair");
                if (b == FRAME - 1) begin
                    if (f == 3) begin
                        req_valid = 2'b00;
                        #1;
                        check_eq("fair_last_ready", 32'(req_ready), 32'h0);
                    end else begin
                        check_eq("fair_next_ready", 32'(req_ready), 32'(nxt_hot));
                    end
                end else begin
                    tick();
                end
            end
        end
        tick();
        check_idle("fair_end");

        // Full blocking: nothing starts while the synchronized flag is high.
        remote_full = 1'b1;
        repeat (3) tick();
        req_valid = 2'b10;
        #1;
        for (int c = 0; c < 3; c++) begin
            check_eq("full_block_ready", 32'(req_ready), 32'h0);
            check_eq("full_block_valid", 32'(lane_valid), 32'd0);
            tick();
        end
        remote_full = 1'b0;
        #1;
        check_eq("release_t0_ready", 32'(req_ready), 32'h0);
        tick();
        check_eq("release_t1_ready", 32'(req_ready), 32'h0);
        tick();
        check_eq("release_t2_ready", 32'(req_ready), 32'h2);
        push_frame(2'd1, W1);
        tick();

        // Full asserted during DATA beat 2: frame completes, next one held.
        for (int b = 0; b < FRAME; b++) begin
            check_beat("full_mid");
            if (b == 3) remote_full = 1'b1;
            if (b == FRAME - 1) begin
                #1;
                check_eq("full_mid_final_ready", 32'(req_ready), 32'h0);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            check_idle("full_mid_hold");
            check_eq("full_mid_hold_ready", 32'(req_ready), 32'h0);
            tick();
        end

`ifdef SERIAL_LINK_PARITY_EN
        // Parity beat of 32'h0000_0001 is 1.
        req_valid   = 2'b00;
        remote_full = 1'b0;
        repeat (3) tick();
        req_data[0] = 32'h0000_0001;
        req_valid   = 2'b01;
        #1;
        check_eq("par_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        repeat (9) tick();
        check_eq("par_beat", 32'(lane_data), 32'h1);
        check_eq("par_valid", 32'(lane_valid), 32'd1);
        tick();
        check_idle("par_end");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
